// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared definitions for the RAM load arbiter: ownership states,
// host register offsets and the CTRL/STATUS bit positions.
// No ports (package).

package ram_arb_pkg;

  // Ownership of the shared RAM. The encoding is visible to the host in STATUS[2:1].
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } arb_state_t;

  // Avalon-MM register offsets
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_ADDR   = 2'd2;
  localparam logic [1:0] REG_DATA   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_GO_BIT = 0;

  // STATUS bit positions
  localparam int STAT_RDY_BIT   = 0;
  localparam int STAT_STATE_LSB = 1;
  localparam int STAT_ERR_BIT   = 3;

endpackage

// File: rtl/ram_arb_csr.sv
// ram_arb_csr
// Host register block for the RAM load arbiter: decodes Avalon accesses,
// owns the load pointer and the sticky ERR flag, and builds readdata.
// Optional feature: RAM_ARB_READBACK_EN enables stalled DATA reads in LOAD.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   address, chipselect,
//   write_n, read_n, writedata Avalon-MM slave inputs
//   readdata, waitrequest      Avalon-MM slave outputs
//   state, ram_rdy, go         arbiter status for STATUS/CTRL readback
//   ram_busy                   a load write occupies the RAM this cycle
//   ram_rdata                  RAM read data (readback path)
//   go_wr, go_val              CTRL write strobe and written GO value
//   data_wr                    DATA write accepted in LOAD
//   pointer                    load pointer
//   err                        sticky error flag

module ram_arb_csr
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  input  arb_state_t        state,
  input  logic              ram_rdy,
  input  logic              go,
  input  logic              ram_busy,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              go_wr,
  output logic              go_val,
  output logic              data_wr,
  output logic [ADDR_W-1:0] pointer,
  output logic              err
);

  logic bus_wr;
  logic bus_rd;
  logic in_load;
  logic addr_wr;
  logic err_set;
  logic err_clr;
  logic rb_done;
  logic unused_sink;

  assign bus_wr  = chipselect & ~write_n;
  assign bus_rd  = chipselect & ~read_n;
  assign in_load = (state == ST_LOAD);

  assign go_wr   = bus_wr && (address == REG_CTRL);
  assign go_val  = writedata[CTRL_GO_BIT];
  assign data_wr = bus_wr && (address == REG_DATA) && in_load;
  assign addr_wr = bus_wr && (address == REG_ADDR);
  assign err_set = bus_wr && (address == REG_DATA) && !in_load;
  assign err_clr = bus_wr && (address == REG_STATUS) && writedata[STAT_ERR_BIT];

  // Only the low bits of writedata and, in the default build, none of the
  // readback inputs are consumed; fold them into one sink.
  assign unused_sink = ^{writedata, ram_rdata, ram_busy};

`ifdef RAM_ARB_READBACK_EN
  logic rb_req;
  logic rb_phase;

  // A DATA read in LOAD is split into an address phase (stalled) and a data
  // phase one cycle later. If a load write holds the RAM during the address
  // phase the stall simply repeats.
  assign rb_req      = bus_rd && (address == REG_DATA) && in_load;
  assign waitrequest = rb_req && !rb_phase;
  assign rb_done     = rb_req && rb_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_phase <= 1'b0;
    end else begin
      rb_phase <= rb_req && !rb_phase && !ram_busy;
    end
  end
`else
  assign waitrequest = 1'b0;
  assign rb_done     = 1'b0;
`endif

  // Load pointer: explicit loads win; otherwise it advances after each RAM
  // access made on behalf of the host and wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pointer <= '0;
    end else if (addr_wr) begin
      pointer <= writedata[ADDR_W-1:0];
    end else if (data_wr || rb_done) begin
      pointer <= pointer + ADDR_W'(1);
    end
  end

  // Sticky error: a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    if (bus_rd) begin
      case (address)
        REG_CTRL: begin
          readdata[CTRL_GO_BIT] = go;
        end
        REG_STATUS: begin
          readdata[STAT_RDY_BIT]          = ram_rdy;
          readdata[STAT_STATE_LSB +: 2]   = state;
          readdata[STAT_ERR_BIT]          = err;
        end
        REG_ADDR: begin
          readdata = 32'(pointer);
        end
        default: begin
          if (rb_done) readdata = 32'(ram_rdata);
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_load_arbiter.sv
// ram_load_arbiter
// Arbitrates a single-port RAM between a host loader (Avalon-MM slave) and
// the NES core. The host fills the RAM in LOAD, a one-cycle DRAIN separates
// the owners, and the core reads it in RUN.
// Optional feature: RAM_ARB_READBACK_EN (host DATA readback in LOAD).
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   address .. waitrequest          Avalon-MM register interface
//   core_req, core_addr, core_gnt,
//   core_rvalid, core_rdata         core read port
//   ram_addr, ram_we, ram_wdata,
//   ram_rdata                       single-port RAM, 1-cycle read latency
//   ram_rdy                         RAM owned by core (registered)

module ram_load_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_rdy
);

  arb_state_t        state;
  logic              go_q;
  logic              go_wr;
  logic              go_val;
  logic              data_wr;
  logic              err;
  logic [ADDR_W-1:0] pointer;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              ram_we_q;

  ram_arb_csr #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_csr (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .read_n      (read_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .state       (state),
    .ram_rdy     (ram_rdy),
    .go          (go_q),
    .ram_busy    (ram_we_q),
    .ram_rdata   (ram_rdata),
    .go_wr       (go_wr),
    .go_val      (go_val),
    .data_wr     (data_wr),
    .pointer     (pointer),
    .err         (err)
  );

  // Ownership FSM. go_q remembers which way a DRAIN is heading and is what
  // the host reads back as CTRL.GO. ram_rdy is updated together with the
  // state so it is high exactly for RUN cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_LOAD;
      go_q    <= 1'b0;
      ram_rdy <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (go_wr && go_val) begin
            go_q  <= 1'b1;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state   <= go_q ? ST_RUN : ST_LOAD;
          ram_rdy <= go_q;
        end
        ST_RUN: begin
          if (go_wr && !go_val) begin
            go_q    <= 1'b0;
            state   <= ST_DRAIN;
            ram_rdy <= 1'b0;
          end
        end
        default: begin
          state   <= ST_LOAD;
          go_q    <= 1'b0;
          ram_rdy <= 1'b0;
        end
      endcase
    end
  end

  // Host load writes are registered so the RAM sees a clean one-cycle
  // strobe; reset drops any pending write immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_we_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      ram_we_q <= data_wr;
      if (data_wr) begin
        wr_addr_q <= pointer;
        wr_data_q <= writedata[DATA_W-1:0];
      end
    end
  end

  // Core read returns one cycle after the grant, matching RAM latency. A
  // grant in the last RUN cycle still completes during DRAIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_rvalid <= 1'b0;
    end else begin
      core_rvalid <= core_gnt;
    end
  end

  assign core_gnt   = (state == ST_RUN) && core_req;
  assign core_rdata = ram_rdata;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = wr_data_q;

  // In RUN the core address goes straight to the RAM; otherwise a pending
  // load write has priority over the pointer (used by readback).
  always_comb begin
    if (state == ST_RUN) begin
      ram_addr = core_addr;
    end else if (ram_we_q) begin
      ram_addr = wr_addr_q;
    end else begin
      ram_addr = pointer;
    end
  end

  logic unused_err;
  assign unused_err = err;

endmodule

// File: tb/tb_ram_load_arbiter.sv
// tb_ram_load_arbiter
// Self-checking bench for ram_load_arbiter with a behavioural 64K x 8 RAM.
// Table-driven register/load vectors, then hand-written sequences for the
// ownership hand-over, error flag, coincident GO=0, readback
// (RAM_ARB_READBACK_EN) and reset during a core read.

module tb_ram_load_arbiter;
  import ram_arb_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        core_req;
  logic [15:0] core_addr;
  logic        core_gnt;
  logic        core_rvalid;
  logic [7:0]  core_rdata;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_rdy;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:65535];

  ram_load_arbiter #(
    .ADDR_W(16),
    .DATA_W(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .read_n      (read_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .core_req    (core_req),
    .core_addr   (core_addr),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .ram_rdy     (ram_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, one cycle read latency
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        is_write;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        exp_we;
    logic [15:0] exp_ram_addr;
    logic [7:0]  exp_wdata;
    logic [31:0] exp_read;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // One-cycle Avalon write; returns just after the edge that accepted it.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    #1;
  endtask

  // Combinational Avalon read of one register.
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic wr);
    @(negedge clk);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = a;
    #1;
    d  = readdata;
    wr = waitrequest;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] rd;
    logic        wr;
    if (v.is_write) begin
      bus_write(v.addr, v.data);
      checkOutput($sformatf("vec%0d_we", idx), ram_we, v.exp_we);
      if (v.exp_we) begin
        checkOutput($sformatf("vec%0d_ram_addr", idx), ram_addr, v.exp_ram_addr);
        checkOutput($sformatf("vec%0d_ram_wdata", idx), ram_wdata, v.exp_wdata);
      end
    end else begin
      bus_read(v.addr, rd, wr);
      checkOutput($sformatf("vec%0d_readdata", idx), rd, v.exp_read);
      checkOutput($sformatf("vec%0d_waitreq", idx), wr, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        wr;

    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    writedata  = 32'h0;
    core_req   = 1'b1;
    core_addr  = 16'h0;

    // Reset state (core_req held high to show the grant is blocked)
    #12;
    checkOutput("rst_ram_rdy", ram_rdy, 1'b0);
    checkOutput("rst_ram_we", ram_we, 1'b0);
    checkOutput("rst_core_gnt", core_gnt, 1'b0);
    checkOutput("rst_core_rvalid", core_rvalid, 1'b0);
    checkOutput("rst_readdata", readdata, 32'h0);
    checkOutput("rst_waitreq", waitrequest, 1'b0);
    @(negedge clk);
    reset    = 1'b0;
    core_req = 1'b0;

    // {is_write, addr, data, exp_we, exp_ram_addr, exp_wdata, exp_read}
    vecs.push_back('{1'b1, REG_ADDR,   32'h0000_0010, 1'b0, 16'h0000, 8'h00, 32'h0});
    vecs.push_back('{1'b1, REG_DATA,   32'h0000_00A5, 1'b1, 16'h0010, 8'hA5, 32'h0});
    vecs.push_back('{1'b1, REG_DATA,   32'h0000_005A, 1'b1, 16'h0011, 8'h5A, 32'h0});
    vecs.push_back('{1'b0, REG_ADDR,   32'h0,         1'b0, 16'h0000, 8'h00, 32'h0000_0012});
    vecs.push_back('{1'b0, REG_STATUS, 32'h0,         1'b0, 16'h0000, 8'h00, 32'h0});
    vecs.push_back('{1'b0, REG_CTRL,   32'h0,         1'b0, 16'h0000, 8'h00, 32'h0});
    vecs.push_back('{1'b1, REG_ADDR,   32'h0000_FFFF, 1'b0, 16'h0000, 8'h00, 32'h0});
    vecs.push_back('{1'b1, REG_DATA,   32'h0000_0011, 1'b1, 16'hFFFF, 8'h11, 32'h0});
    vecs.push_back('{1'b0, REG_ADDR,   32'h0,         1'b0, 16'h0000, 8'h00, 32'h0});
    vecs.push_back('{1'b1, REG_DATA,   32'h0000_01FF, 1'b1, 16'h0000, 8'hFF, 32'h0});
    vecs.push_back('{1'b0, REG_ADDR,   32'h0,         1'b0, 16'h0000, 8'h00, 32'h0000_0001});
    vecs.push_back('{1'b1, REG_CTRL,   32'h0000_0002, 1'b0, 16'h0000, 8'h00, 32'h0});
    vecs.push_back('{1'b0, REG_STATUS, 32'h0,         1'b0, 16'h0000, 8'h00, 32'h0});
    vecs.push_back('{1'b1, REG_ADDR,   32'h0001_2345, 1'b0, 16'h0000, 8'h00, 32'h0});
    vecs.push_back('{1'b0, REG_ADDR,   32'h0,         1'b0, 16'h0000, 8'h00, 32'h0000_2345});
    vecs.push_back('{1'b1, REG_ADDR,   32'h0000_0012, 1'b0, 16'h0000, 8'h00, 32'h0});
    vecs.push_back('{1'b1, REG_DATA,   32'h0000_005A, 1'b1, 16'h0012, 8'h5A, 32'h0});
    vecs.push_back('{1'b0, REG_ADDR,   32'h0,         1'b0, 16'h0000, 8'h00, 32'h0000_0013});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // LOAD -> DRAIN -> RUN, then core reads
    bus_write(REG_CTRL, 32'h1);
    core_req  = 1'b1;
    core_addr = 16'h0010;
    #1;
    checkOutput("drain_ram_rdy", ram_rdy, 1'b0);
    checkOutput("drain_core_gnt", core_gnt, 1'b0);
    @(negedge clk);
    core_addr = 16'h0012;
    #1;
    checkOutput("run_ram_rdy", ram_rdy, 1'b1);
    checkOutput("run_core_gnt", core_gnt, 1'b1);
    checkOutput("run_first_rvalid", core_rvalid, 1'b0);
    @(negedge clk);
    core_addr = 16'h0010;
    #1;
    checkOutput("core_rvalid_12", core_rvalid, 1'b1);
    checkOutput("core_rdata_12", core_rdata, 8'h5A);
    @(negedge clk);
    core_req = 1'b0;
    #1;
    checkOutput("core_rvalid_10", core_rvalid, 1'b1);
    checkOutput("core_rdata_10", core_rdata, 8'hA5);
    @(negedge clk);
    #1;
    checkOutput("core_rvalid_idle", core_rvalid, 1'b0);

    bus_read(REG_STATUS, rd, wr);
    checkOutput("run_status", rd, 32'h5);
    bus_read(REG_CTRL, rd, wr);
    checkOutput("run_ctrl", rd, 32'h1);
    bus_read(REG_DATA, rd, wr);
    checkOutput("run_data_read", rd, 32'h0);
    checkOutput("run_data_waitreq", wr, 1'b0);

    // DATA write outside LOAD sets ERR; STATUS bit3 clears it
    bus_write(REG_DATA, 32'h77);
    checkOutput("run_data_wr_we", ram_we, 1'b0);
    bus_read(REG_STATUS, rd, wr);
    checkOutput("err_set_status", rd, 32'hD);
    bus_write(REG_STATUS, 32'h8);
    bus_read(REG_STATUS, rd, wr);
    checkOutput("err_clr_status", rd, 32'h5);
    bus_read(REG_ADDR, rd, wr);
    checkOutput("run_pointer_held", rd, 32'h13);

    // GO=0 coincident with a core request: granted, then hand-over
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = REG_CTRL;
    writedata  = 32'h0;
    core_req   = 1'b1;
    core_addr  = 16'h0010;
    #1;
    checkOutput("stop_core_gnt", core_gnt, 1'b1);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    #1;
    checkOutput("stop_drain_rvalid", core_rvalid, 1'b1);
    checkOutput("stop_drain_rdata", core_rdata, 8'hA5);
    checkOutput("stop_drain_gnt", core_gnt, 1'b0);
    checkOutput("stop_drain_rdy", ram_rdy, 1'b0);
    @(negedge clk);
    core_req = 1'b0;
    #1;
    checkOutput("stop_load_rvalid", core_rvalid, 1'b0);
    bus_read(REG_STATUS, rd, wr);
    checkOutput("stop_load_status", rd, 32'h0);

`ifdef RAM_ARB_READBACK_EN
    bus_write(REG_ADDR, 32'h10);
    @(negedge clk);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = REG_DATA;
    #1;
    checkOutput("rb_wait_first", waitrequest, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("rb_wait_second", waitrequest, 1'b0);
    checkOutput("rb_readdata", readdata, 32'h0000_00A5);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read_n     = 1'b1;
    bus_read(REG_ADDR, rd, wr);
    checkOutput("rb_pointer", rd, 32'h11);
`else
    bus_read(REG_DATA, rd, wr);
    checkOutput("load_data_read", rd, 32'h0);
    checkOutput("load_data_waitreq", wr, 1'b0);
    bus_read(REG_ADDR, rd, wr);
    checkOutput("load_data_ptr", rd, 32'h13);
`endif

    // Reset in the middle of a core read
    bus_write(REG_CTRL, 32'h1);
    @(negedge clk);
    core_req  = 1'b1;
    core_addr = 16'h0011;
    @(posedge clk);
    #2;
    checkOutput("mid_rvalid_before", core_rvalid, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_rvalid", core_rvalid, 1'b0);
    checkOutput("mid_rst_rdy", ram_rdy, 1'b0);
    checkOutput("mid_rst_gnt", core_gnt, 1'b0);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = REG_DATA;
    writedata  = 32'h33;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_we", ram_we, 1'b0);
    chipselect = 1'b0;
    write_n    = 1'b1;
    @(negedge clk);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = REG_STATUS;
    #1;
    checkOutput("mid_rst_status", readdata, 32'h0);
    chipselect = 1'b0;
    read_n     = 1'b1;
    core_req   = 1'b0;
    reset      = 1'b0;
    bus_read(REG_ADDR, rd, wr);
    checkOutput("post_rst_pointer", rd, 32'h0);
    bus_read(REG_STATUS, rd, wr);
    checkOutput("post_rst_status", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
